// File: rtl/fenotipo_pkg.sv
// Shared definitions for the serial phenotype loader.
// Holds the loader state encoding and the helpers that size the chromosome and
// locate the LE / output fields inside it.
package fenotipo_pkg;

  localparam int unsigned DEF_N_LES    = 29;
  localparam int unsigned DEF_LE_BITS  = 15;
  localparam int unsigned DEF_N_OUTS   = 8;
  localparam int unsigned DEF_OUT_BITS = 6;
  localparam int unsigned DEF_IN_W     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CHK  = 2'd2,
    FULL = 2'd3
  } state_t;

  // Total chromosome width: LE fields followed by output selector fields.
  function automatic int unsigned chrom_width(input int unsigned n_les,
                                              input int unsigned le_bits,
                                              input int unsigned n_outs,
                                              input int unsigned out_bits);
    return n_les * le_bits + n_outs * out_bits;
  endfunction

  // Number of stream beats needed to carry chrom_w bits.
  function automatic int unsigned beat_count(input int unsigned chrom_w,
                                             input int unsigned in_w);
    return (chrom_w + in_w - 1) / in_w;
  endfunction

  // LSB of LE k inside the chromosome.
  function automatic int unsigned le_lsb(input int unsigned k,
                                         input int unsigned le_bits);
    return k * le_bits;
  endfunction

  // LSB of output selector j inside the chromosome.
  function automatic int unsigned out_lsb(input int unsigned j,
                                          input int unsigned n_les,
                                          input int unsigned le_bits,
                                          input int unsigned out_bits);
    return n_les * le_bits + j * out_bits;
  endfunction

endpackage

// File: rtl/fenotipo_serial_loader_shadow.sv
// cromossomo_shadow: shadow chromosome register, beat counter and (optionally)
// the running XOR of the data beats.
// Optional feature macro: FENOTIPO_CHECKSUM_EN (adds the csum output).
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   wr            store data at beat slot 'count' and advance the counter
//   clr_cnt       restart the beat counter (and checksum accumulator)
//   clr_all       clear shadow, counter and accumulator
//   data          incoming beat
//   chrom         shadow chromosome contents
//   last_beat     the next stored beat is the final data beat
//   csum          XOR of stored data beats, padding bits zeroed (feature only)
module cromossomo_shadow
  import fenotipo_pkg::*;
#(
  parameter int unsigned CHROM_W = 483,
  parameter int unsigned IN_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr,
  input  logic               clr_cnt,
  input  logic               clr_all,
  input  logic [IN_W-1:0]    data,
  output logic [CHROM_W-1:0] chrom,
  output logic               last_beat
`ifdef FENOTIPO_CHECKSUM_EN
  ,
  output logic [IN_W-1:0]    csum
`endif
);

  localparam int unsigned BEATS = beat_count(CHROM_W, IN_W);
  localparam int unsigned CNT_W = $clog2(BEATS + 1);

  logic [CNT_W-1:0]   count;
  logic [CHROM_W-1:0] wr_data_c;
  logic [CHROM_W-1:0] wr_mask_c;

  // Map every chromosome bit to its beat slot; padding bits of the last beat
  // have no slot and are simply never written.
  for (genvar b = 0; b < BEATS; b++) begin : g_beat
    for (genvar k = 0; k < IN_W; k++) begin : g_bit
      if (b * IN_W + k < CHROM_W) begin : g_map
        assign wr_data_c[b*IN_W+k] = data[k];
        assign wr_mask_c[b*IN_W+k] = wr && (count == CNT_W'(b));
      end
    end
  end

  // Shadow register: one beat slot updated per write.
  always_ff @(posedge clk) begin
    if (rst || clr_all) begin
      chrom <= '0;
    end else begin
      chrom <= (chrom & ~wr_mask_c) | (wr_data_c & wr_mask_c);
    end
  end

  // Beat counter with a registered look-ahead flag for the final data beat.
  always_ff @(posedge clk) begin
    if (rst || clr_all || clr_cnt) begin
      count     <= '0;
      last_beat <= (BEATS == 1);
    end else if (wr) begin
      count     <= count + CNT_W'(1);
      last_beat <= ((count + CNT_W'(1)) == CNT_W'(BEATS - 1));
    end
  end

`ifdef FENOTIPO_CHECKSUM_EN
  localparam int unsigned      PAD_W     = BEATS * IN_W - CHROM_W;
  localparam logic [IN_W-1:0]  LAST_MASK = {IN_W{1'b1}} >> PAD_W;

  logic [IN_W-1:0] beat_x_c;

  // Padding bits do not contribute to the checksum.
  always_comb begin
    beat_x_c = data;
    if (last_beat) begin
      beat_x_c = data & LAST_MASK;
    end
  end

  // Running XOR of the accepted data beats.
  always_ff @(posedge clk) begin
    if (rst || clr_all || clr_cnt) begin
      csum <= '0;
    end else if (wr) begin
      csum <= csum ^ beat_x_c;
    end
  end
`endif

endmodule

// File: rtl/fenotipo_serial_loader.sv
// fenotipo_serial_loader: streams a chromosome into a shadow register and
// commits it atomically to the active configuration driving the genetic circuit.
// Optional feature macro: FENOTIPO_CHECKSUM_EN (trailing XOR checksum beat).
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   s_data/s_valid/s_ready   chromosome beat stream
//   abort         discard the partial or complete shadow
//   apply         commit request (ignored when AUTO_APPLY=1)
//   conf_les      active LE fields, LE k at [k*LE_BITS +: LE_BITS]
//   conf_outs     active output fields, output j at [j*OUT_BITS +: OUT_BITS]
//   conf_valid    active register holds a committed chromosome
//   applied       one-cycle pulse on commit
//   loading       load in progress (LOAD/CHK)
//   err           one-cycle pulse on checksum failure
module fenotipo_serial_loader
  import fenotipo_pkg::*;
#(
  parameter int unsigned N_LES      = DEF_N_LES,
  parameter int unsigned LE_BITS    = DEF_LE_BITS,
  parameter int unsigned N_OUTS     = DEF_N_OUTS,
  parameter int unsigned OUT_BITS   = DEF_OUT_BITS,
  parameter int unsigned IN_W       = DEF_IN_W,
  parameter int unsigned AUTO_APPLY = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [IN_W-1:0]             s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic                        abort,
  input  logic                        apply,
  output logic [N_LES*LE_BITS-1:0]    conf_les,
  output logic [N_OUTS*OUT_BITS-1:0]  conf_outs,
  output logic                        conf_valid,
  output logic                        applied,
  output logic                        loading,
  output logic                        err
);

  localparam int unsigned LES_W    = N_LES * LE_BITS;
  localparam int unsigned OUTS_W   = N_OUTS * OUT_BITS;
  localparam int unsigned CHROM_W  = chrom_width(N_LES, LE_BITS, N_OUTS, OUT_BITS);
  localparam int unsigned OUTS_LSB = out_lsb(0, N_LES, LE_BITS, OUT_BITS);

`ifdef FENOTIPO_CHECKSUM_EN
  localparam state_t DATA_DONE = CHK;
`else
  localparam state_t DATA_DONE = FULL;
`endif

  state_t             state;
  state_t             state_next;
  logic               wr_c;
  logic               clr_cnt_c;
  logic               clr_all_c;
  logic               commit_c;
  logic               last_beat;
  logic [CHROM_W-1:0] chrom;
`ifdef FENOTIPO_CHECKSUM_EN
  logic [IN_W-1:0]    csum;
  logic               err_c;
`endif

  cromossomo_shadow #(
    .CHROM_W (CHROM_W),
    .IN_W    (IN_W)
  ) u_shadow (
    .clk       (clk),
    .rst       (rst),
    .wr        (wr_c),
    .clr_cnt   (clr_cnt_c),
    .clr_all   (clr_all_c),
    .data      (s_data),
    .chrom     (chrom),
    .last_beat (last_beat)
`ifdef FENOTIPO_CHECKSUM_EN
    ,
    .csum      (csum)
`endif
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and shadow control. s_ready is high in every state but FULL,
  // so a valid beat outside FULL is a transfer unless abort drops it.
  always_comb begin
    state_next = state;
    wr_c       = 1'b0;
    clr_cnt_c  = 1'b0;
    clr_all_c  = 1'b0;
    commit_c   = 1'b0;
`ifdef FENOTIPO_CHECKSUM_EN
    err_c      = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (s_valid) begin
          wr_c       = 1'b1;
          state_next = last_beat ? DATA_DONE : LOAD;
        end
      end
      LOAD: begin
        if (abort) begin
          clr_cnt_c  = 1'b1;
          state_next = IDLE;
        end else if (s_valid) begin
          wr_c = 1'b1;
          if (last_beat) begin
            state_next = DATA_DONE;
          end
        end
      end
`ifdef FENOTIPO_CHECKSUM_EN
      CHK: begin
        if (abort) begin
          clr_cnt_c  = 1'b1;
          state_next = IDLE;
        end else if (s_valid) begin
          if (s_data == csum) begin
            state_next = FULL;
          end else begin
            err_c      = 1'b1;
            clr_all_c  = 1'b1;
            state_next = IDLE;
          end
        end
      end
`endif
      FULL: begin
        if (abort) begin
          clr_cnt_c  = 1'b1;
          state_next = IDLE;
        end else if ((AUTO_APPLY != 0) || apply) begin
          commit_c   = 1'b1;
          clr_cnt_c  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered status outputs and the active configuration register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_ready    <= 1'b1;
      loading    <= 1'b0;
      applied    <= 1'b0;
      conf_valid <= 1'b0;
      conf_les   <= '0;
      conf_outs  <= '0;
    end else begin
      s_ready <= (state_next != FULL);
      loading <= (state_next == LOAD) || (state_next == CHK);
      applied <= commit_c;
      if (commit_c) begin
        conf_les   <= chrom[LES_W-1:0];
        conf_outs  <= chrom[OUTS_LSB +: OUTS_W];
        conf_valid <= 1'b1;
      end
    end
  end

`ifdef FENOTIPO_CHECKSUM_EN
  // Checksum failure pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      err <= err_c;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fenotipo_serial_loader.sv
// Self-checking bench: a manual-apply and an auto-apply loader share one
// stimulus stream; a beat-array reference model predicts both every cycle.
module tb_fenotipo_serial_loader;

  localparam int unsigned IN_W    = 8;
  localparam int unsigned LES_W   = 29 * 15;
  localparam int unsigned OUTS_W  = 8 * 6;
  localparam int unsigned CHROM_W = LES_W + OUTS_W;
  localparam int unsigned BEATS   = (CHROM_W + IN_W - 1) / IN_W;
`ifdef FENOTIPO_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [IN_W-1:0] s_data;
  logic            s_valid;
  logic            abort;
  logic            apply;

  logic [1:0]        s_ready_w, conf_valid_w, applied_w, loading_w, err_w;
  logic [LES_W-1:0]  conf_les_w  [2];
  logic [OUTS_W-1:0] conf_outs_w [2];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Reference model state per instance (0 = manual apply, 1 = auto apply).
  logic [IN_W-1:0]    m_beats  [2][BEATS];
  logic [CHROM_W-1:0] m_active [2];
  int                 m_got    [2];
  bit                 m_full   [2];
  bit                 m_cv     [2];
  bit                 m_applied[2];
  bit                 m_err    [2];
  bit                 m_took   [2];

  logic [IN_W-1:0] stream_q[$];

  always #5 clk = ~clk;

  fenotipo_serial_loader #(
    .N_LES(29), .LE_BITS(15), .N_OUTS(8), .OUT_BITS(6), .IN_W(IN_W), .AUTO_APPLY(0)
  ) u_dut_m (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_w[0]),
    .abort(abort), .apply(apply), .conf_les(conf_les_w[0]), .conf_outs(conf_outs_w[0]),
    .conf_valid(conf_valid_w[0]), .applied(applied_w[0]), .loading(loading_w[0]),
    .err(err_w[0])
  );

  fenotipo_serial_loader #(
    .N_LES(29), .LE_BITS(15), .N_OUTS(8), .OUT_BITS(6), .IN_W(IN_W), .AUTO_APPLY(1)
  ) u_dut_a (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_w[1]),
    .abort(abort), .apply(apply), .conf_les(conf_les_w[1]), .conf_outs(conf_outs_w[1]),
    .conf_valid(conf_valid_w[1]), .applied(applied_w[1]), .loading(loading_w[1]),
    .err(err_w[1])
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Chromosome assembled from the model's stored beats (padding dropped).
  function automatic logic [CHROM_W-1:0] model_chrom(input int i);
    logic [CHROM_W-1:0] r;
    for (int k = 0; k < CHROM_W; k++) r[k] = m_beats[i][k / IN_W][k % IN_W];
    return r;
  endfunction

  function automatic logic [IN_W-1:0] model_xor(input int i);
    logic [IN_W-1:0] x = '0;
    for (int n = 0; n < BEATS; n++)
      for (int b = 0; b < IN_W; b++)
        if (n * IN_W + b < CHROM_W) x[b] = x[b] ^ m_beats[i][n][b];
    return x;
  endfunction

  // Chromosome carried by the current stimulus stream.
  function automatic logic [CHROM_W-1:0] stream_chrom();
    logic [CHROM_W-1:0] r;
    logic [IN_W-1:0]    b;
    for (int k = 0; k < CHROM_W; k++) begin
      b    = stream_q[k / IN_W];
      r[k] = b[k % IN_W];
    end
    return r;
  endfunction

  task automatic model_step(input int i);
    m_applied[i] = 1'b0;
    m_err[i]     = 1'b0;
    m_took[i]    = 1'b0;
    if (rst) begin
      m_got[i] = 0; m_full[i] = 1'b0; m_cv[i] = 1'b0; m_active[i] = '0;
    end else if (m_full[i]) begin
      if (abort) begin
        m_full[i] = 1'b0; m_got[i] = 0;
      end else if (i == 1 || apply) begin
        m_active[i] = model_chrom(i); m_cv[i] = 1'b1; m_applied[i] = 1'b1;
        m_full[i] = 1'b0; m_got[i] = 0;
      end
    end else if (m_got[i] < BEATS) begin
      if (abort && m_got[i] != 0) begin
        m_got[i] = 0;
      end else if (s_valid) begin
        m_beats[i][m_got[i]] = s_data;
        m_got[i]++;
        m_took[i] = 1'b1;
        if (m_got[i] == BEATS && !CSUM) m_full[i] = 1'b1;
      end
    end else begin
      if (abort) begin
        m_got[i] = 0;
      end else if (s_valid) begin
        m_took[i] = 1'b1;
        if (s_data == model_xor(i)) m_full[i] = 1'b1;
        else begin m_err[i] = 1'b1; m_got[i] = 0; end
      end
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i);
  end

  // Every-cycle comparison of both loaders against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        logic [CHROM_W-1:0] a;
        a = m_active[i];
        check($sformatf("s_ready%0d", i),    s_ready_w[i],    !m_full[i]);
        check($sformatf("loading%0d", i),    loading_w[i],    (m_got[i] != 0) && !m_full[i]);
        check($sformatf("applied%0d", i),    applied_w[i],    m_applied[i]);
        check($sformatf("err%0d", i),        err_w[i],        m_err[i]);
        check($sformatf("conf_valid%0d", i), conf_valid_w[i], m_cv[i]);
        check($sformatf("conf_les%0d", i),   conf_les_w[i],   a[LES_W-1:0]);
        check($sformatf("conf_outs%0d", i),  conf_outs_w[i],  a[CHROM_W-1:LES_W]);
      end
    end
  end

  // kind 0: beat n = n; kind 1: random. bad flips the checksum LSB.
  task automatic build_stream(input int kind, input bit bad);
    logic [IN_W-1:0] b;
    logic [IN_W-1:0] x = '0;
    logic [IN_W-1:0] pad_mask = {IN_W{1'b1}} >> (BEATS * IN_W - CHROM_W);
    stream_q.delete();
    for (int n = 0; n < BEATS; n++) begin
      b = (kind == 0) ? IN_W'(n) : IN_W'($urandom);
      stream_q.push_back(b);
      x = x ^ ((n == BEATS - 1) ? (b & pad_mask) : b);
    end
    if (CSUM) stream_q.push_back(x ^ (bad ? IN_W'(1) : IN_W'(0)));
  endtask

  // Plays stream_q into the manual loader; abort_at / rst_at stop at that beat.
  task automatic play_stream(input int gap_pct, input int abort_at, input int rst_at);
    int n = 0;
    int guard = 0;
    while (n < stream_q.size() && guard < 2000) begin
      s_valid = ($urandom_range(99) >= gap_pct);
      s_data  = s_valid ? stream_q[n] : IN_W'($urandom);
      abort   = s_valid && (n == abort_at);
      rst     = s_valid && (n == rst_at);
      @(negedge clk);
      guard++;
      if (abort || rst) break;
      if (m_took[0]) n++;
    end
    if (guard >= 2000) check("stream_budget", 0, 1);
    s_valid = 1'b0; abort = 1'b0; rst = 1'b0;
  endtask

  task automatic pulse_apply();
    apply = 1'b1;
    @(negedge clk);
    apply = 1'b0;
  endtask

  initial begin
    logic [CHROM_W-1:0] exp_c;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; abort = 1'b0; apply = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_s_ready", s_ready_w[0], 1);
    check("rst_conf_valid", conf_valid_w[0], 0);
    rst = 1'b0;
    @(negedge clk);

    // Ramp stream, then apply.
    build_stream(0, 1'b0);
    play_stream(0, -1, -1);
    check("full_s_ready", s_ready_w[0], 0);
    @(negedge clk);
    check("auto_applied", applied_w[1], 1);
    check("auto_le0", conf_les_w[1][14:0], 15'h0100);
    pulse_apply();
    check("apply_pulse", applied_w[0], 1);
    check("ramp_le0", conf_les_w[0][14:0], 15'h0100);
    check("ramp_out0", conf_outs_w[0][5:0], 6'h26);
    check("ramp_valid", conf_valid_w[0], 1);
    check("ramp_ready", s_ready_w[0], 1);

    // Backpressure: gaps, then s_valid held high in FULL.
    build_stream(1, 1'b0);
    play_stream(30, -1, -1);
    exp_c = stream_chrom();
    for (int k = 0; k < 5; k++) begin
      s_valid = 1'b1; s_data = IN_W'($urandom);
      @(negedge clk);
      check("bp_hold_ready", s_ready_w[0], 0);
    end
    s_valid = 1'b0;
    pulse_apply();
    check("bp_les", conf_les_w[0], exp_c[LES_W-1:0]);
    check("bp_outs", conf_outs_w[0], exp_c[CHROM_W-1:LES_W]);
    abort = 1'b1; @(negedge clk); abort = 1'b0;

    // Abort on beat 30.
    build_stream(1, 1'b0);
    play_stream(20, 30, -1);
    check("abort_loading", loading_w[0], 0);
    check("abort_keep_les", conf_les_w[0], exp_c[LES_W-1:0]);

    // Abort together with apply.
    build_stream(1, 1'b0);
    play_stream(0, -1, -1);
    abort = 1'b1; apply = 1'b1;
    @(negedge clk);
    abort = 1'b0; apply = 1'b0;
    check("abort_apply_applied", applied_w[0], 0);
    check("abort_apply_ready", s_ready_w[0], 1);
    check("abort_apply_keep", conf_les_w[0], exp_c[LES_W-1:0]);

    // Reset on beat 40, then a fresh load.
    build_stream(1, 1'b0);
    play_stream(10, -1, 40);
    check("rst_mid_valid", conf_valid_w[0], 0);
    check("rst_mid_les", conf_les_w[0], 0);
    check("rst_mid_ready", s_ready_w[0], 1);
    build_stream(1, 1'b0);
    play_stream(10, -1, -1);
    exp_c = stream_chrom();
    pulse_apply();
    check("fresh_applied", applied_w[0], 1);
    check("fresh_les", conf_les_w[0], exp_c[LES_W-1:0]);
    check("fresh_outs", conf_outs_w[0], exp_c[CHROM_W-1:LES_W]);

`ifdef FENOTIPO_CHECKSUM_EN
    // Corrupted checksum beat.
    build_stream(1, 1'b1);
    play_stream(10, -1, -1);
    check("csum_err", err_w[0], 1);
    check("csum_loading", loading_w[0], 0);
    @(negedge clk);
    check("csum_err_pulse", err_w[0], 0);
    check("csum_keep", conf_les_w[0], exp_c[LES_W-1:0]);
`endif

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      s_valid = ($urandom_range(99) < 75);
      s_data  = IN_W'($urandom);
      abort   = ($urandom_range(99) < 2);
      apply   = ($urandom_range(99) < 15);
      rst     = ($urandom_range(999) < 3);
      @(negedge clk);
    end
    s_valid = 1'b0; abort = 1'b0; apply = 1'b0; rst = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
